// File: rtl/vga_sync_gen_pkg.sv
// Default 640x480@60 VGA timing constants, derived totals, sync window bounds
// and the sync polarity encoding shared by the sync generator and its users.
package vga_timing_pkg;

  // Pixel coordinates are 10 bits wide, so line and frame totals cap at 1024.
  localparam int COORD_W     = 10;
  localparam int COORD_LIMIT = 1 << COORD_W;
  typedef logic [COORD_W-1:0] coord_t;

  // Sync polarity encoding: the value is the level driven while sync is asserted.
  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  // 50 MHz system clock divided down to the 25 MHz pixel rate.
  localparam int DEF_CLK_DIV = 2;

  // Horizontal timing, in pixels.
  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_H_TOTAL   = DEF_H_DISPLAY + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

  // Vertical timing, in lines.
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;
  localparam int DEF_V_TOTAL   = DEF_V_DISPLAY + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Inclusive sync windows for the default mode (656..751 and 490..491).
  localparam int DEF_HS_START = DEF_H_DISPLAY + DEF_H_FP;
  localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC - 1;
  localparam int DEF_VS_START = DEF_V_DISPLAY + DEF_V_FP;
  localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC - 1;

  // True when v lies in the inclusive range lo..hi.
  function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Pin level for a sync signal given whether it is asserted and its polarity.
  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Timing bundle produced by the VGA sync generator and consumed by the
// graphics stage that picks a colour for each pixel.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic   p_tick;
  coord_t pixel_x;
  coord_t pixel_y;
  logic   video_on;
  logic   hsync;
  logic   vsync;
  logic   frame_tick;

  // The timing generator drives the bundle.
  modport master (
    output p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_tick
  );

  // Graphics/animation logic observes it.
  modport slave (
    input p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_tick
  );

endinterface

// File: rtl/vga_sync_gen_pixel_tick_div.sv
// Mod-CLK_DIV enable generator: tick is high on the last system clock of each
// pixel period. With CLK_DIV=1 the counter is pinned at 0 and tick stays high.
module pixel_tick_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t LAST = cnt_t'(CLK_DIV - 1);

  cnt_t div_cnt;

  // Divider counter: 0..CLK_DIV-1, wrapping, cleared by reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Decoded from the register so the enable is glitch-free and reset-coherent.
  assign tick = (div_cnt == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate enable, horizontal/vertical counters,
// registered sync/blanking outputs and a once-per-frame tick at the start of
// vertical blanking. All outputs are registered from the next-state counters
// so they line up with pixel_x/pixel_y on the same clock.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit SYNC_POL  = SYNC_ACTIVE_LOW
) (
  input logic            clk,
  input logic            rst,
  vga_sync_gen_if.master vga
);

  localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

  // Configurations the 10-bit counters cannot represent are rejected up front.
  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("vga_sync_gen: CLK_DIV must be at least 1");
  end
  if (H_TOTAL > COORD_LIMIT || H_TOTAL < 1) begin : g_bad_h_total
    $error("vga_sync_gen: H_TOTAL must be in 1..1024");
  end
  if (V_TOTAL > COORD_LIMIT || V_TOTAL < 1) begin : g_bad_v_total
    $error("vga_sync_gen: V_TOTAL must be in 1..1024");
  end

  localparam coord_t X_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t Y_LAST = coord_t'(V_TOTAL - 1);
  localparam coord_t X_VIS  = coord_t'(H_DISPLAY);
  localparam coord_t Y_VIS  = coord_t'(V_DISPLAY);
  localparam coord_t HS_LO  = coord_t'(H_DISPLAY + H_FP);
  localparam coord_t HS_HI  = coord_t'(H_DISPLAY + H_FP + H_SYNC - 1);
  localparam coord_t VS_LO  = coord_t'(V_DISPLAY + V_FP);
  localparam coord_t VS_HI  = coord_t'(V_DISPLAY + V_FP + V_SYNC - 1);

  logic   p_tick;
  coord_t pixel_x;
  coord_t pixel_y;
  coord_t x_next;
  coord_t y_next;
  logic   video_on;
  logic   hsync;
  logic   vsync;
  logic   frame_tick;

  pixel_tick_div #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_div (
    .clk (clk),
    .rst (rst),
    .tick(p_tick)
  );

  // Next pixel position: advance on p_tick, wrap the line, then the frame.
  // NOTE: x_next/y_next get a default before any branch so every path assigns
  // them and no latch is inferred.
  always_comb begin
    x_next = pixel_x;
    y_next = pixel_y;
    if (p_tick) begin
      if (pixel_x == X_LAST) begin
        x_next = '0;
        y_next = (pixel_y == Y_LAST) ? coord_t'(0) : pixel_y + 1'b1;
      end else begin
        x_next = pixel_x + 1'b1;
      end
    end
  end

  // Counters and decoded outputs, all taken from the next position so they
  // stay coherent; reset parks on the last pixel of the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_x    <= X_LAST;
      pixel_y    <= Y_LAST;
      video_on   <= 1'b0;
      hsync      <= sync_level(1'b0, SYNC_POL);
      vsync      <= sync_level(1'b0, SYNC_POL);
      frame_tick <= 1'b0;
    end else begin
      pixel_x    <= x_next;
      pixel_y    <= y_next;
      video_on   <= (x_next < X_VIS) && (y_next < Y_VIS);
      hsync      <= sync_level(in_window(x_next, HS_LO, HS_HI), SYNC_POL);
      vsync      <= sync_level(in_window(y_next, VS_LO, VS_HI), SYNC_POL);
      // Only the advancing edge into (0,V_DISPLAY) fires; the hold clocks of
      // that pixel see p_tick low and clear it again.
      frame_tick <= p_tick && (x_next == '0) && (y_next == Y_VIS);
    end
  end

  assign vga.p_tick     = p_tick;
  assign vga.pixel_x    = pixel_x;
  assign vga.pixel_y    = pixel_y;
  assign vga.video_on   = video_on;
  assign vga.hsync      = hsync;
  assign vga.vsync      = vsync;
  assign vga.frame_tick = frame_tick;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen: one full-size 640x480 instance plus
// two reduced-geometry instances (CLK_DIV=2, and CLK_DIV=1 with active-high
// sync) so whole frames fit in a short run.
module tb_vga_sync_gen;
  import vga_timing_pkg::*;

  typedef struct packed {
    int hd; int hfp; int hs; int hbp;
    int vd; int vfp; int vs; int vbp;
    int div; bit pol;
  } geom_t;

  typedef struct packed {
    logic       p_tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       frame_tick;
  } vga_out_t;

  localparam geom_t G_DEF = '{hd:640, hfp:16, hs:96, hbp:48, vd:480, vfp:10, vs:2, vbp:33, div:2, pol:1'b0};
  localparam geom_t G_SM2 = '{hd:20, hfp:3, hs:5, hbp:4, vd:12, vfp:2, vs:2, vbp:3, div:2, pol:1'b0};
  localparam geom_t G_SM1 = '{hd:20, hfp:3, hs:5, hbp:4, vd:12, vfp:2, vs:2, vbp:3, div:1, pol:1'b1};
  localparam int SM_FRAME = 32 * 19;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;

  always #5 clk = ~clk;

  vga_sync_gen_if if_def ();
  vga_sync_gen_if if_sm2 ();
  vga_sync_gen_if if_sm1 ();

  vga_sync_gen #(
    .CLK_DIV(G_DEF.div), .H_DISPLAY(G_DEF.hd), .H_FP(G_DEF.hfp), .H_SYNC(G_DEF.hs), .H_BP(G_DEF.hbp),
    .V_DISPLAY(G_DEF.vd), .V_FP(G_DEF.vfp), .V_SYNC(G_DEF.vs), .V_BP(G_DEF.vbp), .SYNC_POL(G_DEF.pol)
  ) u_def (.clk(clk), .rst(rst), .vga(if_def));

  vga_sync_gen #(
    .CLK_DIV(G_SM2.div), .H_DISPLAY(G_SM2.hd), .H_FP(G_SM2.hfp), .H_SYNC(G_SM2.hs), .H_BP(G_SM2.hbp),
    .V_DISPLAY(G_SM2.vd), .V_FP(G_SM2.vfp), .V_SYNC(G_SM2.vs), .V_BP(G_SM2.vbp), .SYNC_POL(G_SM2.pol)
  ) u_sm2 (.clk(clk), .rst(rst), .vga(if_sm2));

  vga_sync_gen #(
    .CLK_DIV(G_SM1.div), .H_DISPLAY(G_SM1.hd), .H_FP(G_SM1.hfp), .H_SYNC(G_SM1.hs), .H_BP(G_SM1.hbp),
    .V_DISPLAY(G_SM1.vd), .V_FP(G_SM1.vfp), .V_SYNC(G_SM1.vs), .V_BP(G_SM1.vbp), .SYNC_POL(G_SM1.pol)
  ) u_sm1 (.clk(clk), .rst(rst), .vga(if_sm1));

  vga_out_t obs_def, obs_sm2, obs_sm1;
  assign obs_def = {if_def.p_tick, if_def.pixel_x, if_def.pixel_y, if_def.video_on,
                    if_def.hsync, if_def.vsync, if_def.frame_tick};
  assign obs_sm2 = {if_sm2.p_tick, if_sm2.pixel_x, if_sm2.pixel_y, if_sm2.video_on,
                    if_sm2.hsync, if_sm2.vsync, if_sm2.frame_tick};
  assign obs_sm1 = {if_sm1.p_tick, if_sm1.pixel_x, if_sm1.pixel_y, if_sm1.video_on,
                    if_sm1.hsync, if_sm1.vsync, if_sm1.frame_tick};

  // Reference: c clocks after reset release, floor(c/div) pixels have elapsed
  // since the parked position (H_TOTAL-1, V_TOTAL-1); everything else follows
  // from the resulting raster position.
  function automatic vga_out_t model(input geom_t g, input longint c);
    longint ht, vt, adv, idx, x, y;
    vga_out_t m;
    ht  = g.hd + g.hfp + g.hs + g.hbp;
    vt  = g.vd + g.vfp + g.vs + g.vbp;
    adv = c / g.div;
    idx = (ht * vt - 1 + adv) % (ht * vt);
    x   = idx % ht;
    y   = idx / ht;
    m.p_tick     = ((c % g.div) == g.div - 1);
    m.x          = 10'(x);
    m.y          = 10'(y);
    m.video_on   = (x < g.hd) && (y < g.vd);
    m.hsync      = (x >= g.hd + g.hfp && x < g.hd + g.hfp + g.hs) ? g.pol : !g.pol;
    m.vsync      = (y >= g.vd + g.vfp && y < g.vd + g.vfp + g.vs) ? g.pol : !g.pol;
    m.frame_tick = (x == 0) && (y == g.vd) && ((c % g.div) == 0);
    return m;
  endfunction

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // Hold reset for n clocks, release it; the current negedge is cycle 0.
  task automatic apply_reset(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    vga_out_t want;
    want = {1'b0, 10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0};
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (obs_def !== want) begin
        errors++;
        $display("FAIL reset_hold clk=%0d got=%h want=%h", i, obs_def, want);
      end
      checks++;
      if (obs_sm1 !== model(G_SM1, 0)) begin
        errors++;
        $display("FAIL reset_hold_div1 clk=%0d got=%h want=%h", i, obs_sm1, model(G_SM1, 0));
      end
    end
    rst = 1'b0;
    cyc = 0;
    checks++;
    if (obs_def !== want) begin
      errors++;
      $display("FAIL reset_cycle0 got=%h want=%h", obs_def, want);
    end
    step();
    want = {1'b1, 10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0};
    checks++;
    if (obs_def !== want) begin
      errors++;
      $display("FAIL reset_cycle1 got=%h want=%h", obs_def, want);
    end
    step();
    want = {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    checks++;
    if (obs_def !== want) begin
      errors++;
      $display("FAIL reset_cycle2 got=%h want=%h", obs_def, want);
    end
  endtask

  // Continues from cycle 2 of test_reset: one full line of row 0.
  task automatic test_line();
    vga_out_t want;
    int hs_low = 0, vid_low = 0, ticks = 0;
    int hs_min = 1023, hs_max = 0, vid_min = 1023;
    repeat (2 * 800) begin
      want = model(G_DEF, cyc);
      checks++;
      if (obs_def !== want) begin
        errors++;
        $display("FAIL line_model cyc=%0d got=%h want=%h", cyc, obs_def, want);
      end
      if (obs_def.hsync == 1'b0) begin
        hs_low++;
        if (int'(obs_def.x) < hs_min) hs_min = int'(obs_def.x);
        if (int'(obs_def.x) > hs_max) hs_max = int'(obs_def.x);
      end
      if (!obs_def.video_on) begin
        vid_low++;
        if (int'(obs_def.x) < vid_min) vid_min = int'(obs_def.x);
      end
      if (obs_def.p_tick) ticks++;
      step();
    end
    checks++;
    if (hs_min != 656 || hs_max != 751 || hs_low != 192) begin
      errors++;
      $display("FAIL line_hsync_window got=%0d..%0d (%0d clks) want=656..751 (192 clks)", hs_min, hs_max, hs_low);
    end
    checks++;
    if (vid_min != 640 || vid_low != 320) begin
      errors++;
      $display("FAIL line_video_blank got_start=%0d clks=%0d want_start=640 clks=320", vid_min, vid_low);
    end
    checks++;
    if (ticks != 800) begin
      errors++;
      $display("FAIL line_p_tick_count got=%0d want=800", ticks);
    end
  endtask

  task automatic test_frame();
    vga_out_t want;
    int ft_cnt = 0, ft_x = -1, ft_y = -1, vs_clks = 0, vs_min = 1023, vs_max = 0;
    apply_reset(int'($urandom_range(1, 6)));
    repeat (2 * SM_FRAME + 4) begin
      want = model(G_SM2, cyc);
      checks++;
      if (obs_sm2 !== want) begin
        errors++;
        $display("FAIL frame_model cyc=%0d got=%h want=%h", cyc, obs_sm2, want);
      end
      if (obs_sm2.frame_tick) begin
        ft_cnt++;
        ft_x = int'(obs_sm2.x);
        ft_y = int'(obs_sm2.y);
      end
      if (obs_sm2.vsync == 1'b0) begin
        vs_clks++;
        if (int'(obs_sm2.y) < vs_min) vs_min = int'(obs_sm2.y);
        if (int'(obs_sm2.y) > vs_max) vs_max = int'(obs_sm2.y);
      end
      step();
    end
    checks++;
    if (ft_cnt != 1 || ft_x != 0 || ft_y != 12) begin
      errors++;
      $display("FAIL frame_tick_once got=%0d pulses at (%0d,%0d) want=1 at (0,12)", ft_cnt, ft_x, ft_y);
    end
    checks++;
    if (vs_min != 14 || vs_max != 15 || vs_clks != 128) begin
      errors++;
      $display("FAIL frame_vsync_rows got=%0d..%0d (%0d clks) want=14..15 (128 clks)", vs_min, vs_max, vs_clks);
    end
  endtask

  task automatic test_frame_period();
    longint ticks_at[$];
    int max_x = 0, max_y = 0;
    apply_reset(int'($urandom_range(1, 6)));
    repeat (3 * 2 * SM_FRAME + 200) begin
      if (obs_sm2.frame_tick) ticks_at.push_back(cyc);
      if (int'(obs_sm2.x) > max_x) max_x = int'(obs_sm2.x);
      if (int'(obs_sm2.y) > max_y) max_y = int'(obs_sm2.y);
      step();
    end
    checks++;
    if (ticks_at.size() < 3) begin
      errors++;
      $display("FAIL period_tick_count got=%0d want>=3", ticks_at.size());
    end else begin
      for (int i = 1; i < ticks_at.size(); i++) begin
        checks++;
        if (ticks_at[i] - ticks_at[i-1] != 2 * SM_FRAME) begin
          errors++;
          $display("FAIL period_spacing got=%0d want=%0d", ticks_at[i] - ticks_at[i-1], 2 * SM_FRAME);
        end
      end
    end
    checks++;
    if (max_x > 31 || max_y > 18) begin
      errors++;
      $display("FAIL period_bounds got max=(%0d,%0d) want<=(31,18)", max_x, max_y);
    end
  endtask

  task automatic test_mid_reset();
    vga_out_t want;
    vga_out_t want_def;
    int tx, ty;
    longint target;
    want     = {1'b0, 10'd31, 10'd18, 1'b0, 1'b1, 1'b1, 1'b0};
    want_def = {1'b0, 10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int it = 0; it < 3; it++) begin
      apply_reset(int'($urandom_range(1, 3)));
      tx = int'($urandom_range(23, 27));
      ty = int'($urandom_range(14, 15));
      target = longint'((ty * 32 + tx + 1) * 2 + int'($urandom_range(0, 1)));
      while (cyc < target) begin
        step();
      end
      checks++;
      if (obs_sm2 !== model(G_SM2, cyc) || obs_sm2.hsync !== 1'b0 || obs_sm2.vsync !== 1'b0) begin
        errors++;
        $display("FAIL midrst_before got=%h want=%h at (%0d,%0d)", obs_sm2, model(G_SM2, cyc), tx, ty);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (obs_sm2 !== want) begin
        errors++;
        $display("FAIL midrst_after got=%h want=%h", obs_sm2, want);
      end
      checks++;
      if (obs_def !== want_def) begin
        errors++;
        $display("FAIL midrst_after_full got=%h want=%h", obs_def, want_def);
      end
      rst = 1'b0;
      cyc = 0;
      repeat (3) begin
        checks++;
        if (obs_sm2 !== model(G_SM2, cyc)) begin
          errors++;
          $display("FAIL midrst_restart cyc=%0d got=%h want=%h", cyc, obs_sm2, model(G_SM2, cyc));
        end
        step();
      end
    end
  endtask

  task automatic test_div1();
    longint ticks_at[$];
    int ptick_low = 0;
    apply_reset(int'($urandom_range(1, 4)));
    checks++;
    if (obs_sm1.p_tick !== 1'b1 || obs_sm1.x !== 10'd31 || obs_sm1.y !== 10'd18) begin
      errors++;
      $display("FAIL div1_cycle0 got=%h want p_tick=1 at (31,18)", obs_sm1);
    end
    step();
    checks++;
    if (obs_sm1.x !== 10'd0 || obs_sm1.y !== 10'd0 || obs_sm1.video_on !== 1'b1) begin
      errors++;
      $display("FAIL div1_cycle1 got=(%0d,%0d) video_on=%b want=(0,0) video_on=1", obs_sm1.x, obs_sm1.y, obs_sm1.video_on);
    end
    repeat (2 * SM_FRAME + 100) begin
      checks++;
      if (obs_sm1 !== model(G_SM1, cyc)) begin
        errors++;
        $display("FAIL div1_model cyc=%0d got=%h want=%h", cyc, obs_sm1, model(G_SM1, cyc));
      end
      if (obs_sm1.p_tick !== 1'b1) ptick_low++;
      if (obs_sm1.frame_tick) ticks_at.push_back(cyc);
      step();
    end
    checks++;
    if (ptick_low != 0) begin
      errors++;
      $display("FAIL div1_p_tick_low got=%0d clks want=0", ptick_low);
    end
    checks++;
    if (ticks_at.size() < 2) begin
      errors++;
      $display("FAIL div1_tick_count got=%0d want>=2", ticks_at.size());
    end else if (ticks_at[1] - ticks_at[0] != SM_FRAME) begin
      errors++;
      $display("FAIL div1_period got=%0d want=%0d", ticks_at[1] - ticks_at[0], SM_FRAME);
    end
  endtask

  task automatic test_random_resets();
    int n;
    for (int it = 0; it < 4; it++) begin
      apply_reset(int'($urandom_range(1, 6)));
      n = int'($urandom_range(50, 1500));
      repeat (n) begin
        checks++;
        if (obs_def !== model(G_DEF, cyc)) begin
          errors++;
          $display("FAIL rand_full cyc=%0d got=%h want=%h", cyc, obs_def, model(G_DEF, cyc));
        end
        checks++;
        if (obs_sm2 !== model(G_SM2, cyc)) begin
          errors++;
          $display("FAIL rand_div2 cyc=%0d got=%h want=%h", cyc, obs_sm2, model(G_SM2, cyc));
        end
        checks++;
        if (obs_sm1 !== model(G_SM1, cyc)) begin
          errors++;
          $display("FAIL rand_div1 cyc=%0d got=%h want=%h", cyc, obs_sm1, model(G_SM1, cyc));
        end
        step();
      end
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_frame_period();
    test_mid_reset();
    test_div1();
    test_random_resets();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Timing generator for 640x480@60 VGA. It derives the pixel-rate enable from the system clock and runs the horizontal and vertical pixel counters.
- It produces registered hsync/vsync, video_on and the pixel coordinates. The pong graphics/animation stage consumes these to select per-pixel colour.
- It also emits a clean one-clock frame_tick at the start of vertical blanking. Animation logic uses it for its once-per-frame position update.

Parameters:
- CLK_DIV, 2: system clocks per pixel; legal range ≥1. 50 MHz clk gives a 25 MHz pixel rate.
- H_DISPLAY, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync pulse width, in pixels.
- H_BP, 48: horizontal back porch, in pixels. Line total H_TOTAL = 800.
- V_DISPLAY, 480: visible lines.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync pulse width, in lines.
- V_BP, 33: vertical back porch, in lines. Frame total V_TOTAL = 525.
- SYNC_POL, 0: active sync level; 0 means active-low. Inactive level is ~SYNC_POL.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- p_tick  out  1  high on the last clk of each pixel period; counters advance on that edge
- pixel_x  out  10  current column, 0..H_TOTAL-1
- pixel_y  out  10  current row, 0..V_TOTAL-1
- video_on  out  1  high when pixel_x<H_DISPLAY and pixel_y<V_DISPLAY
- hsync  out  1  horizontal sync, at SYNC_POL level while asserted
- vsync  out  1  vertical sync, at SYNC_POL level while asserted
- frame_tick  out  1  one-clk pulse on the first clk where (pixel_x,pixel_y)=(0,V_DISPLAY)

Behaviour:
- Single clock domain. Reset is synchronous and active-high; rst has priority over every other update.
- div_cnt:
  - Counts 0..CLK_DIV-1 and wraps to 0; reset value 0.
  - p_tick = (div_cnt==CLK_DIV-1), decoded from the register.
  - With CLK_DIV=1, p_tick is constantly 1 after reset.
- Pixel counters:
  - Reset values: pixel_x=H_TOTAL-1 (799), pixel_y=V_TOTAL-1 (524). The first advancing edge therefore lands on (0,0) coherently.
  - On a clk edge with p_tick=1: pixel_x increments. On reaching H_TOTAL-1 it wraps to 0 and pixel_y increments.
  - pixel_y wraps to 0 after V_TOTAL-1, only when pixel_x also wraps.
  - With p_tick=0, all counters and outputs hold.
- Registered outputs:
  - video_on, hsync, vsync and frame_tick are registers computed from the next-state counter values. They are always coherent with pixel_x/pixel_y, with zero relative latency.
- hsync asserted when H_DISPLAY+H_FP ≤ pixel_x ≤ H_DISPLAY+H_FP+H_SYNC-1, i.e. 656..751.
- vsync asserted when V_DISPLAY+V_FP ≤ pixel_y ≤ V_DISPLAY+V_FP+V_SYNC-1, i.e. rows 490..491.
- Reset values of outputs:
  - video_on=0, hsync=vsync=~SYNC_POL, frame_tick=0.
  - p_tick=0 when CLK_DIV>1; p_tick=1 when CLK_DIV=1.
  - These are consistent with position (799,524).
- frame_tick:
  - Set only on the p_tick edge that moves the counters to (0,480); cleared on the next clk.
  - Exactly one pulse per frame regardless of CLK_DIV.
- Timing from reset deassertion, default CLK_DIV=2:
  - cycle 0: div=0.
  - cycle 1: p_tick=1.
  - cycle 2: first clk showing (0,0) with video_on=1.
- Period of frame_tick = H_TOTAL*V_TOTAL*CLK_DIV clks = 840000 at defaults.
- Reset mid-frame: all state returns to reset values on the next edge. There is no partial sync pulse beyond that edge.
- Width rule: H_TOTAL and V_TOTAL must each be ≤1024. An out-of-range configuration is a elaboration-time error.

Decomposition:
- Package vga_timing_pkg holds the default 640x480@60 constants, the derived H_TOTAL/V_TOTAL, the sync window bounds, and the SYNC_POL encoding.
- One sub-module: pixel_tick_div, a mod-CLK_DIV enable generator with parameter CLK_DIV and ports clk, rst, tick.

Test Plan:
1. Reset held 5 clks, then released → during reset and cycle 0: pixel_x=799, pixel_y=524, video_on=0, hsync=vsync=1, frame_tick=0. Cycle 2: (0,0), video_on=1.
2. Run one line → hsync=0 exactly for pixel_x 656..751. video_on=0 for pixel_x 640..799. p_tick high every 2nd clk.
3. Run one frame → vsync=0 only on rows 490..491. frame_tick high for exactly 1 clk, with pixel_x=0 and pixel_y=480.
4. Run 3 frames → consecutive frame_tick rising edges exactly 840000 clks apart. pixel_y never exceeds 524; pixel_x never exceeds 799.
5. Assert rst for 1 clk at (700,490), with hsync and vsync active → next clk shows (799,524) with both syncs inactive and video_on=0. Sequence then restarts as in test 1.
6. CLK_DIV=1 instance → p_tick=1 continuously. (0,0) appears on cycle 1 after reset. frame_tick period is 420000 clks.
